// File: rtl/enemy_ctrl.sv
// Lane enemy: hit-point FSM (ALIVE/STUNNED/DEAD), per-player attack damage and sprite addressing.
// Optional macro ENEMY_FLASH_EN blinks the sprite while the enemy is stunned.
module enemy_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int ATK_POS_A   = 0,
    parameter int ATK_POS_B   = 10,
    parameter int HP_INIT     = 3,
    parameter int STUN_TICKS  = 4,
    parameter int SPR_W       = 160,
    parameter int SPR_H       = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_PLAYERS-1:0]     hit,
    input  logic [5*NUM_PLAYERS-1:0]   pos,
    input  logic                       revive,
    input  logic [9:0]                 h_cnt,
    input  logic [9:0]                 v_cnt,
    output logic [14:0]                pixel_addr,
    output logic                       visible,
    output logic [NUM_PLAYERS-1:0]     damage,
    output logic [3:0]                 hp,
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        STUNNED = 2'd1,
        DEAD    = 2'd2
    } enemy_state_e;

    enemy_state_e              state_q;
    logic [3:0]                hp_q;
    logic [3:0]                stun_q;
    logic [NUM_PLAYERS-1:0]    hit_q;
    logic [NUM_PLAYERS-1:0]    damage_q;
    logic [14:0]               addr_q;
    logic                      visible_q;
`ifdef ENEMY_FLASH_EN
    logic                      flash_q;
`endif

    logic [NUM_PLAYERS-1:0]    hit_evt;
    logic [7:0]                evt_cnt;
    logic [3:0]                hp_d;
    logic [NUM_PLAYERS-1:0]    damage_d;
    logic                      in_win;
    logic [14:0]               addr_d;
    logic                      visible_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        hit_evt  = hit & ~hit_q;
        evt_cnt  = '0;
        damage_d = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            evt_cnt     = evt_cnt + {7'b0, hit_evt[i]};
            damage_d[i] = (state_q == ALIVE) && !hit[i] &&
                          ((pos[5*i +: 5] == 5'(ATK_POS_A)) || (pos[5*i +: 5] == 5'(ATK_POS_B)));
        end
        hp_d      = ({4'b0, hp_q} > evt_cnt) ? hp_q - evt_cnt[3:0] : 4'd0;
        in_win    = (h_cnt < 10'(SPR_W)) && (v_cnt < 10'(SPR_H));
        addr_d    = in_win ? 15'(v_cnt) * 15'(SPR_W) + 15'(h_cnt) : 15'd0;
        visible_d = in_win && (state_q != DEAD);
`ifdef ENEMY_FLASH_EN
        visible_d = visible_d && !flash_q;
`endif
    end

    // NOTE: all state updates use non-blocking assignments; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIVE;
            hp_q      <= 4'(HP_INIT);
            stun_q    <= '0;
            hit_q     <= '0;
            damage_q  <= '0;
            addr_q    <= '0;
            visible_q <= 1'b0;
`ifdef ENEMY_FLASH_EN
            flash_q   <= 1'b0;
`endif
        end else begin
            hit_q     <= hit;
            damage_q  <= damage_d;
            addr_q    <= addr_d;
            visible_q <= visible_d;
`ifdef ENEMY_FLASH_EN
            if (state_q == STUNNED) begin
                if (tick) flash_q <= ~flash_q;
            end else begin
                flash_q <= 1'b0;
            end
`endif
            case (state_q)
                ALIVE: begin
                    if (evt_cnt != 8'd0) begin
                        hp_q <= hp_d;
                        if (hp_d == 4'd0) begin
                            state_q <= DEAD;
                        end else begin
                            state_q <= STUNNED;
                            stun_q  <= 4'(STUN_TICKS);
                        end
                    end
                end
                STUNNED: begin
                    // Leave one cycle after the counter has run out; hits are ignored.
                    if (stun_q == 4'd0)  state_q <= ALIVE;
                    else if (tick)       stun_q  <= stun_q - 4'd1;
                end
                DEAD: begin
                    hp_q <= '0;
                    if (revive) begin
                        state_q <= ALIVE;
                        hp_q    <= 4'(HP_INIT);
                    end
                end
                default: state_q <= ALIVE;
            endcase
        end
    end

    assign pixel_addr = addr_q;
    assign visible    = visible_q;
    assign damage     = damage_q;
    assign hp         = hp_q;
    assign state      = state_q;

endmodule
